// File: rtl/noc_link_pkg.sv
// rtl/noc_link_pkg.sv - shared serial-link constants and state type
package noc_link_pkg;

  localparam int FLIT_W = 64;
  localparam int NIB_W  = 4;
  localparam int VC_W   = 2;
  localparam int BEATS  = FLIT_W / NIB_W;

  // Receive-side assembly state
  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

endpackage

// File: rtl/flit_hold_reg.sv
// rtl/flit_hold_reg.sv - single-entry valid/ready flit holding register
module flit_hold_reg #(
  parameter int FLIT_W = 64,
  parameter int VC_W   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_valid,
  input  logic [FLIT_W-1:0] load_data,
  input  logic [VC_W-1:0]   load_vc,
  input  logic              ready,
  output logic [FLIT_W-1:0] data,
  output logic [VC_W-1:0]   vc,
  output logic              valid,
  output logic              overflow
);

  // Load when empty or draining this cycle; otherwise drop the newcomer and flag it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data     <= '0;
      vc       <= '0;
      valid    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      overflow <= 1'b0;
      if (load_valid) begin
        if (!valid || ready) begin
          data  <= load_data;
          vc    <= load_vc;
          valid <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/deserializer.sv
// rtl/deserializer.sv - nibble-stream to flit reassembly with error flagging
module deserializer #(
  parameter int FLIT_W = 64,
  parameter int NIB_W  = 4,
  parameter int VC_W   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NIB_W-1:0]  data_in,
  input  logic              valid_in,
  input  logic [VC_W-1:0]   vc_in,
  output logic [FLIT_W-1:0] flit_out,
  output logic              flit_valid,
  output logic [VC_W-1:0]   flit_vc,
  input  logic              flit_ready,
  output logic              busy,
  output logic              err_gap,
  output logic              err_vc,
  output logic              err_overflow
);
  import noc_link_pkg::*;

  localparam int BEATS = FLIT_W / NIB_W;
  localparam int CNT_W = $clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [FLIT_W-1:0] asm_q, asm_d;
  logic [VC_W-1:0]   vc_q, vc_d;
  logic              gap_d, vcerr_d, complete;

  // State, beat counter, assembly buffer and registered error pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      asm_q   <= '0;
      vc_q    <= '0;
      err_gap <= 1'b0;
      err_vc  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      asm_q   <= asm_d;
      vc_q    <= vc_d;
      err_gap <= gap_d;
      err_vc  <= vcerr_d;
    end
  end

  // Next-state: place each beat at its nibble slot, restart on VC change, abort on gap
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    asm_d    = asm_q;
    vc_d     = vc_q;
    gap_d    = 1'b0;
    vcerr_d  = 1'b0;
    complete = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_in) begin
          asm_d[NIB_W-1:0] = data_in;
          vc_d             = vc_in;
          count_d          = CNT_W'(1);
          state_d          = RECV;
        end
      end
      RECV: begin
        if (!valid_in) begin
          gap_d   = 1'b1;
          count_d = '0;
          state_d = IDLE;
        end else if (vc_in != vc_q) begin
          // The offending nibble becomes beat 0 of a fresh flit
          vcerr_d          = 1'b1;
          asm_d[NIB_W-1:0] = data_in;
          vc_d             = vc_in;
          count_d          = CNT_W'(1);
        end else begin
          asm_d[count_q*NIB_W +: NIB_W] = data_in;
          if (count_q == LAST_BEAT) begin
            complete = 1'b1;
            count_d  = '0;
            state_d  = IDLE;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == RECV);

  flit_hold_reg #(
    .FLIT_W (FLIT_W),
    .VC_W   (VC_W)
  ) u_hold (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (complete),
    .load_data  (asm_d),
    .load_vc    (vc_q),
    .ready      (flit_ready),
    .data       (flit_out),
    .vc         (flit_vc),
    .valid      (flit_valid),
    .overflow   (err_overflow)
  );

endmodule
